// File: rtl/arb_req_pkg.sv
// Shared types and helpers for the arbiter requester block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_req_pkg;

  // Burst engine state: wait for a grant, stream beats, acknowledge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int DEF_PORTS   = 4;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 255;

  // Port index width; kept at least 1 so a degenerate config still elaborates.
  function automatic int port_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // LSB of port p's length field inside the packed s_len bus.
  function automatic int len_lsb(input int port, input int len_w);
    return port * len_w;
  endfunction

endpackage

// File: rtl/arb_req_slot.sv
// Per-port command slot: one outstanding burst command, request generation,
// optional grant-wait watchdog (ARB_REQ_WATCHDOG_EN).
// Latency: request rises the cycle after s_valid&s_ready; s_ready rises the cycle after ack.
// Backpressure: s_ready is low while a command is pending, including the ack cycle.
// Ports:
//   clk, rst          clock, async active-high reset
//   s_valid/s_ready   command handshake; s_len latched on accept
//   ack               acknowledge for this slot; pending clears at this edge
//   take              engine accepted this slot's grant in IDLE (clears watchdog)
//   gnt_hit           grant_valid & grant[i] from the arbiter
//   request, len      pending flag and latched length to the engine
//   wdog_err          sticky grant-timeout flag (0 when watchdog not built)
module arb_req_slot
  import arb_req_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [LEN_W-1:0] s_len,
  input  logic             ack,
  input  logic             take,
  input  logic             gnt_hit,
  output logic             request,
  output logic [LEN_W-1:0] len,
  output logic             wdog_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic             pending_q, pending_d;
  logic [LEN_W-1:0] len_q, len_d;

  // Ready comes straight from the registered flag, so a command can never
  // slip in during the ack cycle while pending is still set.
  always_comb begin
    pending_d = pending_q;
    len_d     = len_q;
    if (ack) begin
      pending_d = 1'b0;
    end else if (s_valid && !pending_q) begin
      pending_d = 1'b1;
      len_d     = s_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      len_q     <= '0;
    end else begin
      pending_q <= pending_d;
      len_q     <= len_d;
    end
  end

  assign s_ready = !pending_q;
  assign request = pending_q;
  assign len     = len_q;

`ifdef ARB_REQ_WATCHDOG_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counts cycles spent requesting without holding the grant; saturates.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (take) begin
      cnt_d = '0;
    end else if (pending_q && !gnt_hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CNT_MAX) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign wdog_err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^{take, gnt_hit, CNT_MAX};
  assign wdog_err    = 1'b0;
`endif

endmodule

// File: rtl/arb_requester.sv
// Requester end of an arbiter request/grant/acknowledge link: per-port burst
// commands, one shared beat channel, acknowledge on burst completion.
// Latency: grant seen at edge t -> first beat from t+1; ack one cycle after last beat.
// Backpressure: m_ready low stalls the burst with all m_* held; s_ready low while pending.
// Optional feature macro: ARB_REQ_WATCHDOG_EN (per-port grant-wait watchdog).
// Ports:
//   clk, rst                        clock, async active-high reset
//   s_valid/s_ready/s_len           per-port command (length-1 at [i*LEN_W +: LEN_W])
//   request/acknowledge             to arbiter
//   grant/grant_valid/grant_encoded from arbiter (sampled only in IDLE)
//   m_valid/m_ready/m_port/m_beat/m_last  shared beat channel
//   wdog_err                        sticky grant-timeout flags
module arb_requester
  import arb_req_pkg::*;
#(
  parameter  int PORTS   = DEF_PORTS,
  parameter  int LEN_W   = DEF_LEN_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int PORT_W  = port_w(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       s_valid,
  output logic [PORTS-1:0]       s_ready,
  input  logic [PORTS*LEN_W-1:0] s_len,
  output logic [PORTS-1:0]       request,
  output logic [PORTS-1:0]       acknowledge,
  input  logic [PORTS-1:0]       grant,
  input  logic                   grant_valid,
  input  logic [PORT_W-1:0]      grant_encoded,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PORT_W-1:0]      m_port,
  output logic [LEN_W-1:0]       m_beat,
  output logic                   m_last,
  output logic [PORTS-1:0]       wdog_err
);

  state_t            state_q, state_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic [LEN_W-1:0]  beat_q, beat_d;

  logic [LEN_W-1:0]  len_arr [PORTS];
  logic [PORTS-1:0]  take_vec;
  logic [PORTS-1:0]  ack_vec;
  logic [LEN_W-1:0]  cur_len;
  logic              last_beat;

  for (genvar i = 0; i < PORTS; i++) begin : g_slot
    arb_req_slot #(
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid[i]),
      .s_ready  (s_ready[i]),
      .s_len    (s_len[len_lsb(i, LEN_W) +: LEN_W]),
      .ack      (ack_vec[i]),
      .take     (take_vec[i]),
      .gnt_hit  (grant_valid && grant[i]),
      .request  (request[i]),
      .len      (len_arr[i]),
      .wdog_err (wdog_err[i])
    );
  end

  // Length of the burst in flight, muxed by the latched port.
  always_comb begin
    cur_len = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (port_q == PORT_W'(i)) begin
        cur_len = len_arr[i];
      end
    end
  end

  assign last_beat = (beat_q == cur_len);

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    beat_d   = beat_q;
    take_vec = '0;
    ack_vec  = '0;
    case (state_q)
      ST_IDLE: begin
        // A grant for a port with nothing pending (e.g. a stale re-grant right
        // after our ack) is ignored.
        for (int i = 0; i < PORTS; i++) begin
          if (grant_valid && (grant_encoded == PORT_W'(i)) && request[i]) begin
            take_vec[i] = 1'b1;
            port_d      = grant_encoded;
            beat_d      = '0;
            state_d     = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (m_ready) begin
          if (last_beat) begin
            state_d = ST_ACK;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_ACK: begin
        for (int i = 0; i < PORTS; i++) begin
          if (port_q == PORT_W'(i)) begin
            ack_vec[i] = 1'b1;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      beat_q  <= beat_d;
    end
  end

  assign m_valid     = (state_q == ST_XFER);
  assign m_port      = m_valid ? port_q : '0;
  assign m_beat      = m_valid ? beat_q : '0;
  assign m_last      = m_valid && last_beat;
  assign acknowledge = ack_vec;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester paired with a round-robin, acknowledge-blocking
// arbiter modelled locally.
module tb_arb_requester;

  localparam int PORTS  = 4;
  localparam int LEN_W  = 4;
  localparam int PORT_W = 2;

  logic                   clk;
  logic                   rst;
  logic [PORTS-1:0]       s_valid;
  logic [PORTS-1:0]       s_ready;
  logic [PORTS*LEN_W-1:0] s_len;
  logic [PORTS-1:0]       request;
  logic [PORTS-1:0]       acknowledge;
  logic [PORTS-1:0]       grant;
  logic                   grant_valid;
  logic [PORT_W-1:0]      grant_encoded;
  logic                   m_valid;
  logic                   m_ready;
  logic [PORT_W-1:0]      m_port;
  logic [LEN_W-1:0]       m_beat;
  logic                   m_last;
  logic [PORTS-1:0]       wdog_err;

  int n_tests = 0;
  int n_fail  = 0;

  arb_requester #(
    .PORTS   (PORTS),
    .LEN_W   (LEN_W),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_len         (s_len),
    .request       (request),
    .acknowledge   (acknowledge),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_port        (m_port),
    .m_beat        (m_beat),
    .m_last        (m_last),
    .wdog_err      (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter, grant held until acknowledged by the holder.
  logic [PORT_W-1:0] arb_last;
  logic [PORT_W-1:0] arb_pick;
  logic              arb_found;

  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    for (int k = 1; k <= PORTS; k++) begin
      if (!arb_found && request[(int'(arb_last) + k) % PORTS]) begin
        arb_found = 1'b1;
        arb_pick  = PORT_W'((int'(arb_last) + k) % PORTS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      arb_last      <= PORT_W'(PORTS - 1);
    end else if (grant_valid && |(grant & request) && !(|(grant & acknowledge))) begin
      grant <= grant;
    end else if (arb_found) begin
      grant         <= 4'b0001 << arb_pick;
      grant_valid   <= 1'b1;
      grant_encoded <= arb_pick;
      arb_last      <= arb_pick;
    end else begin
      grant       <= '0;
      grant_valid <= 1'b0;
    end
  end

  // Protocol monitor: never two ack bits, never a beat alongside an ack.
  logic bad_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst && (($countones(acknowledge) > 1) || (m_valid && |acknowledge))) begin
      bad_ack <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int l);
    s_valid[p] = 1'b1;
    s_len[p*LEN_W +: LEN_W] = LEN_W'(l);
    tick();
    s_valid[p] = 1'b0;
  endtask

  task automatic wait_mvalid(input string tag, input int budget);
    for (int n = 0; n < budget && !m_valid; n++) tick();
    check(tag, m_valid, 1);
  endtask

  task automatic wait_ack(input string tag, input int p, input int budget);
    for (int n = 0; n < budget && !acknowledge[p]; n++) tick();
    check(tag, acknowledge[p], 1);
  endtask

  function automatic int onehot_idx(input logic [PORTS-1:0] v);
    int r = -1;
    for (int i = PORTS - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  int ack_port [3];
  int ack_cyc  [3];
  int n_ack;

  initial begin
    rst     = 1'b1;
    s_valid = '0;
    s_len   = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 4'b1111);
    check("rst_request", request, 4'b0000);
    check("rst_m_valid", m_valid, 0);
    check("rst_ack",     acknowledge, 4'b0000);
    check("rst_wdog",    wdog_err, 4'b0000);
    rst = 1'b0;
    tick();

    // Single burst on port 1, len=3.
    send(1, 3);
    check("single_request", request, 4'b0010);
    check("single_s_ready", s_ready, 4'b1101);
    wait_mvalid("single_start", 10);
    for (int k = 0; k < 4; k++) begin
      check("single_valid", m_valid, 1);
      check("single_port",  m_port, 1);
      check("single_beat",  m_beat, k);
      check("single_last",  m_last, (k == 3) ? 1 : 0);
      check("single_noack", acknowledge, 4'b0000);
      tick();
    end
    check("single_ack",       acknowledge, 4'b0010);
    check("single_ack_ready", s_ready[1], 0);
    tick();
    check("single_ack_once",  acknowledge, 4'b0000);
    check("single_ready_back", s_ready[1], 1);

    // Asynchronous reset mid-burst at beat 2.
    send(1, 3);
    wait_mvalid("rstx_start", 10);
    tick();
    tick();
    check("rstx_beat2", m_beat, 2);
    #1 rst = 1'b1;
    #1;
    check("rstx_m_valid", m_valid, 0);
    check("rstx_ack",     acknowledge, 4'b0000);
    check("rstx_request", request, 4'b0000);
    check("rstx_s_ready", s_ready, 4'b1111);
    #1 rst = 1'b0;
    tick();
    tick();
    check("rstx_dropped", m_valid, 0);

    // Contention: ports 0,2,3 at once, len=0.
    s_len = '0;
    s_valid = 4'b1101;
    tick();
    s_valid = '0;
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 3; c++) begin
      if (|acknowledge) begin
        ack_port[n_ack] = onehot_idx(acknowledge);
        ack_cyc[n_ack]  = c;
        n_ack++;
      end
      tick();
    end
    check("cont_nack", n_ack, 3);
    check("cont_order0", ack_port[0], 0);
    check("cont_order1", ack_port[1], 2);
    check("cont_order2", ack_port[2], 3);
    check("cont_gap01", ack_cyc[1] - ack_cyc[0], 3);
    check("cont_gap12", ack_cyc[2] - ack_cyc[1], 3);
    // Arbiter re-grants port 3 after its ack; nothing pending, so no burst.
    tick();
    check("stale_grant_ignored", m_valid, 0);
    tick();

    // Stall: port 3 len=1, m_ready low for 5 cycles on beat 0.
    m_ready = 1'b0;
    send(3, 1);
    wait_mvalid("stall_start", 10);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", m_valid, 1);
      check("stall_port",  m_port, 3);
      check("stall_beat",  m_beat, 0);
      check("stall_noack", acknowledge, 4'b0000);
      tick();
    end
    m_ready = 1'b1;
    check("stall_hold_beat", m_beat, 0);
    tick();
    check("stall_beat1", m_beat, 1);
    check("stall_last",  m_last, 1);
    tick();
    check("stall_ack", acknowledge, 4'b1000);
    tick();
    tick();

    // Back-pressure: s_valid[0] held through the ack.
    s_len[0 +: LEN_W] = '0;
    s_valid[0] = 1'b1;
    tick();
    wait_ack("bp_ack1", 0, 20);
    check("bp_no_accept_in_ack", s_ready[0], 0);
    tick();
    check("bp_ready_after_ack", s_ready[0], 1);
    tick();
    s_valid[0] = 1'b0;
    check("bp_second_accepted", request[0], 1);
    wait_ack("bp_ack2", 0, 20);
    tick();
    tick();

`ifdef ARB_REQ_WATCHDOG_EN
    // Watchdog: port 0 stalled on a long burst while port 2 waits.
    m_ready = 1'b0;
    send(0, 15);
    wait_mvalid("wdog_start", 10);
    send(2, 0);
    for (int k = 0; k < 7; k++) tick();
    check("wdog_before", wdog_err, 4'b0000);
    tick();
    check("wdog_set", wdog_err, 4'b0100);
    m_ready = 1'b1;
    wait_ack("wdog_drain", 2, 80);
    tick();
    check("wdog_sticky", wdog_err, 4'b0100);
`else
    check("wdog_off", wdog_err, 4'b0000);
`endif

    check("ack_protocol", bad_ack, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
